plot_arbiter: RTL and testbench
===============================

PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160: horizontal pixel count; x >= SCREEN_W is off-screen.
REQ-002 SHALL have parameter SCREEN_H, default 120: vertical pixel count; y >= SCREEN_H is off-screen.
REQ-003 SHALL have port CLOCK_50  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port ReqIn  in  3  rectangle-job request per requester: bit0 erase-character, bit1 draw-character, bit2 fruit.
REQ-006 SHALL have port ReqX  in  24  packed origin x, 8 bits per requester, requester i at [8i+7:8i].
REQ-007 SHALL have port ReqY  in  21  packed origin y, 7 bits per requester.
REQ-008 SHALL have port ReqW  in  12  packed width, 4 bits per requester.
REQ-009 SHALL have port ReqH  in  12  packed height, 4 bits per requester.
REQ-010 SHALL have port ReqColor  in  9  packed colour, 3 bits per requester.
REQ-011 SHALL have port XOut  out  8  VGA pixel x.
REQ-012 SHALL have port YOut  out  7  VGA pixel y.
REQ-013 SHALL have port Color  out  3  VGA pixel colour.
REQ-014 SHALL have port Plot  out  1  VGA write enable, one pixel per high cycle.
REQ-015 SHALL have port Grant  out  3  one-hot owner of the current job, zero when idle.
REQ-016 SHALL have port DoneOut  out  3  one-cycle completion pulse to the granted requester.
REQ-017 SHALL have port Busy  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, PLOT, DONE.
REQ-019 IDLE: on the rising edge with ReqIn != 0, SHALL grant by fixed priority bit0 > bit1 > bit2, latch the winner's X/Y/W/H/colour, clear counters cx=cy=0, and enter PLOT.
REQ-020 Job with latched W=0 or H=0 SHALL go IDLE -> DONE directly with no Plot cycle.
REQ-021 PLOT: each cycle SHALL drive XOut=x0+cx, YOut=y0+cy and Color=latched colour, in raster order (cx fastest, then cy).
REQ-022 In PLOT, Plot SHALL be 1 only when the 9-bit sum x0+cx < SCREEN_W and the 8-bit sum y0+cy < SCREEN_H; clipped pixels still consume their cycle.
REQ-023 XOut and YOut SHALL be the truncated low 8 and 7 bits of those sums.
REQ-024 After the pixel at cx=W-1, cy=H-1, SHALL enter DONE; a job therefore lasts 1 + W*H + 1 cycles from grant edge to DoneOut.
REQ-025 DONE: DoneOut[granted] SHALL be 1 for exactly one cycle and the block SHALL then return to IDLE, with Grant cleared on that edge.
REQ-026 A requester SHALL keep ReqIn high until its DoneOut; deasserting ReqIn or changing parameters mid-job SHALL NOT affect the job in progress.
REQ-027 Requests pending at DONE SHALL be arbitrated in the next IDLE cycle; no back-to-back grant skips IDLE.
REQ-028 Outside PLOT, Plot SHALL be 0 and XOut, YOut and Color SHALL be 0.

Reset
REQ-029 Reset high SHALL immediately force IDLE, counters 0, latched parameters 0, and XOut/YOut/Color/Plot/Grant/DoneOut/Busy all 0, aborting any job without a DoneOut pulse.
REQ-030 After Reset falls, arbitration SHALL start at the first rising edge.

Structure
REQ-031 Package plot_pkg SHALL hold the state encoding, requester indices (REQ_ERASE=0, REQ_DRAW=1, REQ_FRUIT=2) and the default screen constants.
REQ-032 Fixed-priority selection SHALL be a sub-module plot_prio_sel (3-bit request in, one-hot grant out, combinational).

Verification
REQ-033 Reset, then ReqIn=001 with x=10, y=20, w=2, h=2 -> Plot high for 4 consecutive cycles at (10,20), (11,20), (10,21), (11,21); DoneOut=001 on the following cycle.
REQ-034 ReqIn=110 raised in the same cycle -> Grant=010 first, Grant=100 only after DoneOut=010 plus one IDLE cycle.
REQ-035 Job at x=158, w=4, h=1 -> 4 PLOT cycles with Plot=1, 1, 0, 0.
REQ-036 Job with w=0 -> no Plot; DoneOut pulses 2 cycles after the grant edge.
REQ-037 Reset asserted during the 3rd PLOT cycle -> all outputs 0 asynchronously, no DoneOut; a re-request then completes normally.
REQ-038 ReqX changed and ReqIn dropped mid-job -> pixel coordinates still follow the latched origin; DoneOut still pulses.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared constants for the plot arbiter: FSM encoding, requester indices, screen size.
// Pure declarations; no logic, no latency, no flow control.
package plot_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLOT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NUM_REQ   = 3;
  localparam int REQ_ERASE = 0;
  localparam int REQ_DRAW  = 1;
  localparam int REQ_FRUIT = 2;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

endpackage

// File: rtl/plot_prio_sel.sv
// Fixed-priority one-hot select: erase beats draw beats fruit.
// Combinational, zero latency; no backpressure.
module plot_prio_sel
  import plot_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt
);

  always_comb begin
    o_gnt            = '0;
    o_gnt[REQ_ERASE] = i_req[REQ_ERASE];
    o_gnt[REQ_DRAW]  = i_req[REQ_DRAW]  & ~i_req[REQ_ERASE];
    o_gnt[REQ_FRUIT] = i_req[REQ_FRUIT] & ~i_req[REQ_ERASE] & ~i_req[REQ_DRAW];
  end

endmodule

// File: rtl/plot_arbiter.sv
// Arbitrates three rectangle-fill jobs onto one VGA pixel port, one pixel per PLOT cycle.
// Job occupies W*H PLOT cycles then one DONE cycle; requesters hold ReqIn until DoneOut.
module plot_arbiter
  import plot_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic [2:0]  ReqIn,
  input  logic [23:0] ReqX,
  input  logic [20:0] ReqY,
  input  logic [11:0] ReqW,
  input  logic [11:0] ReqH,
  input  logic [8:0]  ReqColor,
  output logic [7:0]  XOut,
  output logic [6:0]  YOut,
  output logic [2:0]  Color,
  output logic        Plot,
  output logic [2:0]  Grant,
  output logic [2:0]  DoneOut,
  output logic        Busy
);

  localparam logic [8:0] LP_SCREEN_W = SCREEN_W[8:0];
  localparam logic [7:0] LP_SCREEN_H = SCREEN_H[7:0];

  logic [1:0] r_state;
  logic [2:0] r_grant;
  logic [7:0] r_x0;
  logic [6:0] r_y0;
  logic [3:0] r_w;
  logic [3:0] r_h;
  logic [2:0] r_color;
  logic [3:0] r_cx;
  logic [3:0] r_cy;

  logic [2:0] w_gnt;
  logic [7:0] w_sel_x;
  logic [6:0] w_sel_y;
  logic [3:0] w_sel_w;
  logic [3:0] w_sel_h;
  logic [2:0] w_sel_color;
  logic [8:0] w_sum_x;
  logic [7:0] w_sum_y;
  logic       w_in_plot;
  logic       w_last_col;
  logic       w_last_row;

  plot_prio_sel u_prio_sel (
    .i_req (ReqIn),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_sel_x     = '0;
    w_sel_y     = '0;
    w_sel_w     = '0;
    w_sel_h     = '0;
    w_sel_color = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_x     = ReqX[8*i +: 8];
        w_sel_y     = ReqY[7*i +: 7];
        w_sel_w     = ReqW[4*i +: 4];
        w_sel_h     = ReqH[4*i +: 4];
        w_sel_color = ReqColor[3*i +: 3];
      end
    end
  end

  // Sums are one bit wider than the outputs so off-screen wrap is detected before truncation.
  assign w_sum_x    = {1'b0, r_x0} + {5'b0, r_cx};
  assign w_sum_y    = {1'b0, r_y0} + {4'b0, r_cy};
  assign w_in_plot  = (r_state == ST_PLOT);
  assign w_last_col = (r_cx == r_w - 4'd1);
  assign w_last_row = (r_cy == r_h - 4'd1);

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ReqIn != 3'b000) begin
            r_grant <= w_gnt;
            r_x0    <= w_sel_x;
            r_y0    <= w_sel_y;
            r_w     <= w_sel_w;
            r_h     <= w_sel_h;
            r_color <= w_sel_color;
            r_cx    <= '0;
            r_cy    <= '0;
            r_state <= (w_sel_w == 4'd0 || w_sel_h == 4'd0) ? ST_DONE : ST_PLOT;
          end
        end
        ST_PLOT: begin
          if (w_last_col) begin
            r_cx <= '0;
            if (w_last_row) begin
              r_state <= ST_DONE;
            end else begin
              r_cy <= r_cy + 4'd1;
            end
          end else begin
            r_cx <= r_cx + 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign XOut    = w_in_plot ? w_sum_x[7:0] : 8'd0;
  assign YOut    = w_in_plot ? w_sum_y[6:0] : 7'd0;
  assign Color   = w_in_plot ? r_color : 3'd0;
  assign Plot    = w_in_plot && (w_sum_x < LP_SCREEN_W) && (w_sum_y < LP_SCREEN_H);
  assign Grant   = r_grant;
  assign DoneOut = (r_state == ST_DONE) ? r_grant : 3'b000;
  assign Busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: inputs driven on the falling edge, outputs checked on the next falling edge.
module tb_plot_arbiter;

  logic        CLOCK_50;
  logic        Reset;
  logic [2:0]  ReqIn;
  logic [23:0] ReqX;
  logic [20:0] ReqY;
  logic [11:0] ReqW;
  logic [11:0] ReqH;
  logic [8:0]  ReqColor;
  logic [7:0]  XOut;
  logic [6:0]  YOut;
  logic [2:0]  Color;
  logic        Plot;
  logic [2:0]  Grant;
  logic [2:0]  DoneOut;
  logic        Busy;

  int n_vec = 0;
  int n_err = 0;

  logic [25:0] obs;
  assign obs = {XOut, YOut, Color, Plot, Grant, DoneOut, Busy};

  plot_arbiter dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .ReqIn    (ReqIn),
    .ReqX     (ReqX),
    .ReqY     (ReqY),
    .ReqW     (ReqW),
    .ReqH     (ReqH),
    .ReqColor (ReqColor),
    .XOut     (XOut),
    .YOut     (YOut),
    .Color    (Color),
    .Plot     (Plot),
    .Grant    (Grant),
    .DoneOut  (DoneOut),
    .Busy     (Busy)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [25:0] ev(input int x, input int y, input int c, input int p,
                                     input int g, input int d, input int b);
    return {x[7:0], y[6:0], c[2:0], p[0], g[2:0], d[2:0], b[0]};
  endfunction

  task automatic set_job(input int idx, input int x, input int y, input int w, input int h, input int c);
    ReqX[8*idx +: 8]     = x[7:0];
    ReqY[7*idx +: 7]     = y[6:0];
    ReqW[4*idx +: 4]     = w[3:0];
    ReqH[4*idx +: 4]     = h[3:0];
    ReqColor[3*idx +: 3] = c[2:0];
  endtask

  task automatic test_reset();
    logic [25:0] e;
    set_job(0, 33, 44, 3, 3, 7);
    repeat (2) begin
      @(negedge CLOCK_50);
      e = ev(0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL reset_hold got %h exp %h", obs, e); end
    end
    Reset = 1'b0;
    @(negedge CLOCK_50);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL reset_idle got %h exp %h", obs, e); end
  endtask

  task automatic test_basic();
    logic [25:0] e;
    set_job(0, 10, 20, 2, 2, 3);
    ReqIn = 3'b001;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLOCK_50);
      e = ev(10 + k % 2, 20 + k / 2, 3, 1, 1, 0, 1);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL basic_px k=%0d got %h exp %h", k, obs, e); end
    end
    @(negedge CLOCK_50);
    e = ev(0, 0, 0, 0, 1, 1, 1);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL basic_done got %h exp %h", obs, e); end
    ReqIn = 3'b000;
    @(negedge CLOCK_50);
    e = ev(0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL basic_idle got %h exp %h", obs, e); end
  endtask

  task automatic test_priority();
    logic [25:0] e;
    set_job(1, 5, 5, 1, 1, 3);
    set_job(2, 7, 8, 1, 1, 6);
    ReqIn = 3'b110;
    @(negedge CLOCK_50);
    e = ev(5, 5, 3, 1, 2, 0, 1);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL prio_draw_px got %h exp %h", obs, e); end
    @(negedge CLOCK_50);
    e = ev(0, 0, 0, 0, 2, 2, 1);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL prio_draw_done got %h exp %h", obs, e); end
    ReqIn = 3'b100;
    @(negedge CLOCK_50);
    e = ev(0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL prio_gap_idle got %h exp %h", obs, e); end
    @(negedge CLOCK_50);
    e = ev(7, 8, 6, 1, 4, 0, 1);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL prio_fruit_px got %h exp %h", obs, e); end
    @(negedge CLOCK_50);
    e = ev(0, 0, 0, 0, 4, 4, 1);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL prio_fruit_done got %h exp %h", obs, e); end
    ReqIn = 3'b000;
    @(negedge CLOCK_50);
    e = ev(0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL prio_idle got %h exp %h", obs, e); end
  endtask

  task automatic test_clip();
    int          jx[3] = '{158, 0, 254};
    int          jy[3] = '{0, 119, 0};
    int          jw[3] = '{4, 1, 3};
    int          jh[3] = '{1, 2, 1};
    logic [3:0]  jp[3] = '{4'b0011, 4'b0001, 4'b0000};
    logic [25:0] e;
    for (int j = 0; j < 3; j++) begin
      set_job(0, jx[j], jy[j], jw[j], jh[j], 7);
      ReqIn = 3'b001;
      for (int k = 0; k < jw[j] * jh[j]; k++) begin
        @(negedge CLOCK_50);
        e = ev(jx[j] + k % jw[j], jy[j] + k / jw[j], 7, int'(jp[j][k]), 1, 0, 1);
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL clip j=%0d k=%0d got %h exp %h", j, k, obs, e); end
      end
      @(negedge CLOCK_50);
      e = ev(0, 0, 0, 0, 1, 1, 1);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL clip_done j=%0d got %h exp %h", j, obs, e); end
      ReqIn = 3'b000;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic test_zero();
    logic [25:0] e;
    for (int j = 0; j < 2; j++) begin
      if (j == 0) set_job(0, 3, 3, 0, 3, 5);
      else        set_job(0, 3, 3, 5, 0, 5);
      ReqIn = 3'b001;
      @(negedge CLOCK_50);
      e = ev(0, 0, 0, 0, 1, 1, 1);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL zero_done j=%0d got %h exp %h", j, obs, e); end
      ReqIn = 3'b000;
      @(negedge CLOCK_50);
      e = ev(0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL zero_idle j=%0d got %h exp %h", j, obs, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [25:0] e;
    set_job(0, 0, 0, 4, 1, 5);
    ReqIn = 3'b001;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50);
      e = ev(k, 0, 5, 1, 1, 0, 1);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL rstmid_px k=%0d got %h exp %h", k, obs, e); end
    end
    #2 Reset = 1'b1;
    #1;
    e = ev(0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL rstmid_async got %h exp %h", obs, e); end
    @(negedge CLOCK_50);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL rstmid_nodone got %h exp %h", obs, e); end
    Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLOCK_50);
      e = ev(k, 0, 5, 1, 1, 0, 1);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL rstmid_rerun k=%0d got %h exp %h", k, obs, e); end
    end
    @(negedge CLOCK_50);
    e = ev(0, 0, 0, 0, 1, 1, 1);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL rstmid_done got %h exp %h", obs, e); end
    ReqIn = 3'b000;
    @(negedge CLOCK_50);
  endtask

  task automatic test_latch();
    logic [25:0] e;
    set_job(0, 20, 30, 3, 1, 5);
    ReqIn = 3'b001;
    @(negedge CLOCK_50);
    e = ev(20, 30, 5, 1, 1, 0, 1);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL latch_px0 got %h exp %h", obs, e); end
    set_job(0, 100, 2, 1, 1, 2);
    ReqIn = 3'b000;
    for (int k = 1; k < 3; k++) begin
      @(negedge CLOCK_50);
      e = ev(20 + k, 30, 5, 1, 1, 0, 1);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL latch_px k=%0d got %h exp %h", k, obs, e); end
    end
    @(negedge CLOCK_50);
    e = ev(0, 0, 0, 0, 1, 1, 1);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL latch_done got %h exp %h", obs, e); end
    repeat (2) begin
      @(negedge CLOCK_50);
      e = ev(0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL latch_idle got %h exp %h", obs, e); end
    end
  endtask

  initial begin
    Reset    = 1'b1;
    ReqIn    = '0;
    ReqX     = '0;
    ReqY     = '0;
    ReqW     = '0;
    ReqH     = '0;
    ReqColor = '0;
    test_reset();
    test_basic();
    test_priority();
    test_clip();
    test_zero();
    test_reset_mid();
    test_latch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after 200000 time units, expected bench to finish");
    $fatal(1);
  end

endmodule
